// File: rtl/bcd_down_counter_pkg.sv
// Shared BCD constants and helpers for the countdown counter and its digit cells.
// Loaded values outside 0..9 are clamped to 9 so the count is always valid BCD.
package bcd_down_counter_pkg;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX  = 4'd9;
  localparam bcd_digit_t BCD_ZERO = 4'd0;

  function automatic bcd_digit_t bcd_sat(input bcd_digit_t d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit built from four JK flip-flops.
// Counts 9..0 while borrow_in is high; at 0 it becomes 9 and raises borrow_o.
module bcd_down_digit
  import bcd_down_counter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] d,
  input  logic       borrow_in,
  output logic [3:0] q,
  output logic       is_zero,
  output logic       borrow_o
);

  bcd_digit_t d_sat;
  logic [3:0] j_vec;
  logic [3:0] k_vec;

  assign d_sat = bcd_sat(d);

  // Decrement equations; in load mode J/K force each bit to the loaded value.
  always_comb begin
    j_vec = 4'b0000;
    k_vec = 4'b0000;
    if (load) begin
      j_vec = d_sat;
      k_vec = ~d_sat;
    end else begin
      j_vec[0] = borrow_in;
      k_vec[0] = borrow_in;
      j_vec[1] = borrow_in & ~q[0] & (q[3] | q[2]);
      k_vec[1] = borrow_in & ~q[0];
      j_vec[2] = borrow_in & ~q[0] & q[3];
      k_vec[2] = borrow_in & ~q[1] & ~q[0];
      j_vec[3] = borrow_in & ~q[2] & ~q[1] & ~q[0];
      k_vec[3] = borrow_in & ~q[0];
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_bit
      edge_trigger_JKFF u_ff (
        .clk  (clk),
        .rst_n(~reset),
        .j    (j_vec[gi]),
        .k    (k_vec[gi]),
        .q    (q[gi])
      );
    end
  endgenerate

  assign is_zero  = (q == BCD_ZERO);
  assign borrow_o = borrow_in & is_zero;

endmodule

// File: rtl/edge_trigger_JKFF.sv
// Rising-edge JK flip-flop with asynchronous active-low clear.
module edge_trigger_JKFF (
  input  logic clk,
  input  logic rst_n,
  input  logic j,
  input  logic k,
  output logic q
);

  logic q_q;
  logic q_d;

  always_comb begin
    q_d = q_q;
    unique case ({j, k})
      2'b00: q_d = q_q;
      2'b01: q_d = 1'b0;
      2'b10: q_d = 1'b1;
      2'b11: q_d = ~q_q;
      default: q_d = q_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/bcd_down_counter.sv
// Multi-digit BCD countdown counter with parallel load, zero flag and borrow cascade.
// WRAP selects wrap-to-all-nines or hold-at-zero when counting past zero.
module bcd_down_counter
  import bcd_down_counter_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  enable,
  output logic [4*DIGITS-1:0]   count,
  output logic                  zero,
  output logic                  borrow_out
);

  logic                borrow_chain [DIGITS+1];
  logic [DIGITS-1:0]   digit_zero;
  logic                count_en;

  // In one-shot mode the whole chain is frozen once every digit reaches zero.
  always_comb begin
    zero     = &digit_zero;
    count_en = enable & ~load & (WRAP | ~zero);
  end

  assign borrow_chain[0] = count_en;

  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_down_digit u_digit (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .d        (load_value[4*gi +: 4]),
        .borrow_in(borrow_chain[gi]),
        .q        (count[4*gi +: 4]),
        .is_zero  (digit_zero[gi]),
        .borrow_o (borrow_chain[gi+1])
      );
    end
  endgenerate

  // With WRAP the top of the chain already equals enable & zero & ~load.
  always_comb begin
    if (WRAP) begin
      borrow_out = borrow_chain[DIGITS] & ~reset;
    end else begin
      borrow_out = enable & zero & ~load & ~reset;
    end
  end

endmodule

// File: tb/tb_bcd_down_counter.sv
// Directed bench for the BCD countdown counter: one wrapping and one one-shot instance.
module tb_bcd_down_counter;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic       enable;
  logic [7:0] load_value;
  logic [7:0] count_w, count_h;
  logic       zero_w, zero_h;
  logic       bout_w, bout_h;

  int checks = 0;
  int errors = 0;
  int e;
  int h;

  always #5 clk = ~clk;

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b1)) dut_w (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_value(load_value),
    .enable    (enable),
    .count     (count_w),
    .zero      (zero_w),
    .borrow_out(bout_w)
  );

  bcd_down_counter #(.DIGITS(2), .WRAP(1'b0)) dut_h (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_value(load_value),
    .enable    (enable),
    .count     (count_h),
    .zero      (zero_h),
    .borrow_out(bout_h)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r[7:4] = 4'(v / 10);
    r[3:0] = 4'(v % 10);
    return r;
  endfunction

  initial begin
    reset      = 1'b1;
    load       = 1'b0;
    enable     = 1'b1;
    load_value = 8'h00;
    tick();
    tick();
    chk("rst_count_w", count_w, 8'h00);
    chk("rst_count_h", count_h, 8'h00);
    chk("rst_zero_w", {7'd0, zero_w}, 8'h01);
    chk("rst_bout_w", {7'd0, bout_w}, 8'h00);
    chk("rst_bout_h", {7'd0, bout_h}, 8'h00);

    // Load 57, then assert reset between edges
    reset      = 1'b0;
    enable     = 1'b0;
    load       = 1'b1;
    load_value = 8'h57;
    tick();
    chk("load57_w", count_w, 8'h57);
    chk("load57_h", count_h, 8'h57);
    load   = 1'b0;
    enable = 1'b1;
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_count_w", count_w, 8'h00);
    chk("async_rst_count_h", count_h, 8'h00);
    chk("async_rst_zero_w", {7'd0, zero_w}, 8'h01);
    chk("async_rst_bout_w", {7'd0, bout_w}, 8'h00);
    #1;
    reset  = 1'b0;
    enable = 1'b0;
    tick();
    chk("post_rst_hold", count_w, 8'h00);

    // Load 42 then count 41, 40, 39
    load       = 1'b1;
    enable     = 1'b1;
    load_value = 8'h42;
    tick();
    chk("load42", count_w, 8'h42);
    load = 1'b0;
    tick();
    chk("cnt41", count_w, 8'h41);
    chk("cnt41_bout", {7'd0, bout_w}, 8'h00);
    tick();
    chk("cnt40", count_w, 8'h40);
    tick();
    chk("cnt39_w", count_w, 8'h39);
    chk("cnt39_h", count_h, 8'h39);

    // Load beats enable; non-BCD digits clamp to 9
    load       = 1'b1;
    enable     = 1'b1;
    load_value = 8'h3C;
    tick();
    chk("load3C", count_w, 8'h39);
    load_value = 8'hF5;
    tick();
    chk("loadF5_w", count_w, 8'h95);
    chk("loadF5_h", count_h, 8'h95);

    // Hold for 10 edges at 25
    load_value = 8'h25;
    tick();
    chk("load25", count_w, 8'h25);
    load   = 1'b0;
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("hold25_%0d", i), count_w, 8'h25);
      chk($sformatf("hold25_bout_%0d", i), {7'd0, bout_w}, 8'h00);
    end

    // Zero with enable: wrap vs hold
    load       = 1'b1;
    enable     = 1'b1;
    load_value = 8'h00;
    tick();
    chk("load00", count_w, 8'h00);
    chk("load00_bout_suppressed", {7'd0, bout_w}, 8'h00);
    load = 1'b0;
    #1;
    chk("zero_bout_w", {7'd0, bout_w}, 8'h01);
    chk("zero_bout_h", {7'd0, bout_h}, 8'h01);
    chk("zero_flag_w", {7'd0, zero_w}, 8'h01);
    tick();
    chk("wrap_count_w", count_w, 8'h99);
    chk("wrap_zero_w", {7'd0, zero_w}, 8'h00);
    chk("oneshot_count_h", count_h, 8'h00);
    chk("oneshot_zero_h", {7'd0, zero_h}, 8'h01);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("oneshot_bout_%0d", i), {7'd0, bout_h}, 8'h01);
      tick();
      chk($sformatf("oneshot_count_%0d", i), count_h, 8'h00);
      chk($sformatf("oneshot_zero_%0d", i), {7'd0, zero_h}, 8'h01);
      chk($sformatf("wrap_run_%0d", i), count_w, bcd(99 - i));
    end

    // 100-edge free run from 99
    load       = 1'b1;
    enable     = 1'b0;
    load_value = 8'h99;
    tick();
    chk("load99_w", count_w, 8'h99);
    chk("load99_h", count_h, 8'h99);
    load   = 1'b0;
    enable = 1'b1;
    e = 99;
    h = 99;
    for (int i = 0; i < 100; i++) begin
      chk($sformatf("run_w_%0d", i), count_w, bcd(e));
      chk($sformatf("run_zero_w_%0d", i), {7'd0, zero_w}, {7'd0, e == 0});
      chk($sformatf("run_bout_w_%0d", i), {7'd0, bout_w}, {7'd0, e == 0});
      chk($sformatf("run_h_%0d", i), count_h, bcd(h));
      chk($sformatf("run_bout_h_%0d", i), {7'd0, bout_h}, {7'd0, h == 0});
      tick();
      e = (e == 0) ? 99 : e - 1;
      h = (h == 0) ? 0 : h - 1;
    end
    chk("run_end_w", count_w, 8'h99);
    chk("run_end_h", count_h, 8'h00);
    enable = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
